// File: rtl/dsp_pipe_pkg.sv
// rtl/dsp_pipe_pkg.sv - shared constants and helpers for the DSP pipeline controller
package dsp_pipe_pkg;

  localparam int MAX_STAGES = 16;

  // Width needed to count 0..stages valid stages.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // Increment a counter of the given width, holding at all-ones instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] cur, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (cur >= max_v) ? max_v : cur + 64'd1;
  endfunction

endpackage

// File: rtl/dsp_pipe_ctrl_cell.sv
// rtl/dsp_pipe_ctrl_cell.sv - one stage of the pipeline control chain (valid flag, advance, clock enable)
module dsp_pipe_ctrl_cell (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic up_valid,
  input  logic down_adv,
  output logic adv,
  output logic ce,
  output logic valid,
  output logic valid_nxt
);

  logic valid_q;
  logic valid_d;

  // A stage may advance when it is empty or its occupant moves on; CE fires only for a real beat.
  always_comb begin
    adv     = ~valid_q | down_adv;
    ce      = adv & up_valid & ~flush;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = up_valid;
    end
  end

  // Stage valid flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid     = valid_q;
  assign valid_nxt = valid_d;

endmodule

// File: rtl/dsp_pipe_ctrl.sv
// rtl/dsp_pipe_ctrl.sv - per-stage clock-enable generator for a DSP datapath; DSP_PIPE_CTRL_STATS_EN adds beat/stall counters
module dsp_pipe_ctrl
  import dsp_pipe_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             flush,
  output logic [STAGES-1:0]                stage_ce,
  output logic [STAGES-1:0]                stage_valid,
  output logic [occ_width(STAGES)-1:0]     occupancy,
  output logic [CNT_W-1:0]                 beat_cnt,
  output logic [CNT_W-1:0]                 stall_cnt
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] up_vec;
  logic [STAGES-1:0] ce_vec;
  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] valid_nxt_vec;
  logic [OCC_W-1:0]  occupancy_q;
  logic [OCC_W-1:0]  occupancy_d;

  // Each stage is fed by the one before it; stage 0 is fed by the upstream handshake.
  always_comb begin
    up_vec    = '0;
    up_vec[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      up_vec[i] = valid_vec[i-1];
    end
  end

  // Advance ripples from the tail back to the head so bubbles are collapsed in the same cycle.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic adv;
    logic down_adv;
    if (i == STAGES - 1) begin : g_tail
      assign down_adv = out_ready;
    end else begin : g_mid
      assign down_adv = g_stage[i+1].adv;
    end
    dsp_pipe_ctrl_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .up_valid  (up_vec[i]),
      .down_adv  (down_adv),
      .adv       (adv),
      .ce        (ce_vec[i]),
      .valid     (valid_vec[i]),
      .valid_nxt (valid_nxt_vec[i])
    );
  end

  // Occupancy follows the next-state valid vector so it always matches stage_valid.
  always_comb begin
    occupancy_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy_d = occupancy_d + OCC_W'(valid_nxt_vec[i]);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign stage_valid = valid_vec;
  assign out_valid   = valid_vec[STAGES-1];
  assign occupancy   = occupancy_q;
  // Nothing is accepted or loaded while reset is held.
  assign stage_ce    = ce_vec & {STAGES{~rst}};
  assign in_ready    = g_stage[0].adv & ~flush & ~rst;

`ifdef DSP_PIPE_CTRL_STATS_EN
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] beat_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Saturating delivered-beat and output-stall counters; flush leaves them alone.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_valid & out_ready) begin
      beat_cnt_d = CNT_W'(sat_inc(64'(beat_cnt_q), CNT_W));
    end
    if (out_valid & ~out_ready) begin
      stall_cnt_d = CNT_W'(sat_inc(64'(stall_cnt_q), CNT_W));
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign beat_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// tb/tb_dsp_pipe_ctrl.sv - self-checking bench for dsp_pipe_ctrl with a CE-driven shadow datapath and scoreboard
module tb_dsp_pipe_ctrl;

  localparam int S     = 4;
  localparam int OW    = $clog2(S + 1);
  localparam int CW    = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [S-1:0]  stage_ce;
  logic [S-1:0]  stage_valid;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] stall_cnt;

  dsp_pipe_ctrl #(.STAGES(S), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .stage_ce    (stage_ce),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .beat_cnt    (beat_cnt),
    .stall_cnt   (stall_cnt)
  );

`ifdef DSP_PIPE_CTRL_STATS_EN
  logic       s_in_ready;
  logic       s_out_valid;
  logic [0:0] s_stage_ce;
  logic [0:0] s_stage_valid;
  logic [0:0] s_occupancy;
  logic [1:0] s_beat_cnt;
  logic [1:0] s_stall_cnt;

  dsp_pipe_ctrl #(.STAGES(1), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (s_in_ready),
    .out_valid   (s_out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .stage_ce    (s_stage_ce),
    .stage_valid (s_stage_valid),
    .occupancy   (s_occupancy),
    .beat_cnt    (s_beat_cnt),
    .stall_cnt   (s_stall_cnt)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state and shadow datapath
  logic [S-1:0] m_valid;
  logic [7:0]   dp [S];
  logic [7:0]   in_data;
  logic [7:0]   sb [$];
  int           cyc;
  int           first_acc;
  int           first_ov;
  int           n_deliv;
  int           n_acc;
  logic         last_rdy;
  logic [S-1:0] last_ce;
  logic [S-1:0] last_sv;
  logic [OW-1:0] last_occ;

  function automatic int popcnt(input logic [S-1:0] v);
    int n = 0;
    for (int i = 0; i < S; i++) n += int'(v[i]);
    return n;
  endfunction

  // A stage may advance if any stage from it to the tail is empty, or the tail is being taken.
  task automatic model(input logic [S-1:0] v, input logic iv, input logic ordy, input logic fl,
                       output logic [S-1:0] ce, output logic [S-1:0] nxt, output logic rdy);
    logic [S-1:0] adv;
    logic up;
    for (int i = 0; i < S; i++) begin
      adv[i] = ordy;
      for (int j = i; j < S; j++) if (!v[j]) adv[i] = 1'b1;
    end
    for (int i = 0; i < S; i++) begin
      if (i == 0) up = iv;
      else up = v[i-1];
      ce[i]  = !fl && adv[i] && up;
      nxt[i] = fl ? 1'b0 : (adv[i] ? up : v[i]);
    end
    rdy = adv[0] && !fl;
  endtask

  task automatic step(input logic iv, input logic ordy, input logic fl);
    logic [S-1:0] ce_m;
    logic [S-1:0] nxt_m;
    logic         rdy_m;
    logic [S-1:0] ce_s;
    logic [7:0]   exp_d;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    #3;
    model(m_valid, iv, ordy, fl, ce_m, nxt_m, rdy_m);
    check_eq("in_ready",    32'(in_ready),    32'(rdy_m));
    check_eq("stage_ce",    32'(stage_ce),    32'(ce_m));
    check_eq("stage_valid", 32'(stage_valid), 32'(m_valid));
    check_eq("out_valid",   32'(out_valid),   32'(m_valid[S-1]));
    check_eq("occupancy",   32'(occupancy),   32'(popcnt(m_valid)));
    last_rdy = in_ready;
    last_ce  = stage_ce;
    last_sv  = stage_valid;
    last_occ = occupancy;
    if (iv && in_ready) begin
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (fl) begin
      sb.delete();
    end else begin
      if (iv && rdy_m) sb.push_back(in_data);
      if (out_valid && ordy) n_deliv++;
      if (m_valid[S-1] && ordy) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_d = sb.pop_front();
          check_eq("out_data", 32'(dp[S-1]), 32'(exp_d));
        end
      end
    end
    ce_s = stage_ce;
    @(posedge clk);
    for (int i = S - 1; i >= 0; i--) begin
      if (ce_s[i]) dp[i] = (i == 0) ? in_data : dp[i-1];
    end
    m_valid = nxt_m;
    cyc++;
    #1;
    in_data = in_data + 8'd1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_valid = '0;
    sb.delete();
  endtask

  initial begin
    in_data   = 8'h10;
    cyc       = 0;
    m_valid   = '0;
    first_acc = -1;
    first_ov  = -1;
    n_deliv   = 0;
    n_acc     = 0;
    for (int i = 0; i < S; i++) dp[i] = 8'h00;
    reset_pulse();

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    check_eq("rst_in_ready", 32'(last_rdy), 32'd1);
    check_eq("rst_occ",      32'(last_occ), 32'd0);

    // Streaming: 10 beats with out_ready held high, then drain
    first_acc = -1;
    first_ov  = -1;
    n_deliv   = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 6) begin
        check_eq("ce_steady",  32'(last_ce),  32'hF);
        check_eq("occ_steady", 32'(last_occ), 32'd4);
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    check_eq("stream_latency", 32'(first_ov - first_acc), 32'd4);
    check_eq("stream_beats",   32'(n_deliv), 32'd10);

    // Fill under stall
    n_acc = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    check_eq("fill_accepts", 32'(n_acc),    32'd4);
    check_eq("fill_ready",   32'(last_rdy), 32'd0);
    check_eq("fill_ce",      32'(last_ce),  32'd0);
    check_eq("fill_occ",     32'(last_occ), 32'd4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    // Bubble collapse: build 1010 with the output stalled
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("bubble_sv", 32'(last_sv), 32'b1010);
    check_eq("bubble_ce", 32'(last_ce), 32'b0101);
    step(1'b0, 1'b0, 1'b0);
    check_eq("bubble_next", 32'(last_sv), 32'b1101);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    // Flush mid-stream on a full pipeline
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    check_eq("pre_flush_sv", 32'(last_sv), 32'hF);
    step(1'b1, 1'b1, 1'b1);
    check_eq("flush_ready", 32'(last_rdy), 32'd0);
    check_eq("flush_ce",    32'(last_ce),  32'd0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("post_flush_sv",  32'(last_sv),  32'd0);
    check_eq("post_flush_occ", 32'(last_occ), 32'd0);

    // Async reset between edges on a full pipeline
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_sv",  32'(stage_valid), 32'd0);
    check_eq("arst_ov",  32'(out_valid),   32'd0);
    check_eq("arst_occ", 32'(occupancy),   32'd0);
    check_eq("arst_ce",  32'(stage_ce),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_valid = '0;
    sb.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

`ifdef DSP_PIPE_CTRL_STATS_EN
    reset_pulse();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    check_eq("stall_cnt", 32'(stall_cnt), 32'd3);
    check_eq("beat_cnt",  32'(beat_cnt),  32'd5);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_eq("flush_stall_cnt", 32'(stall_cnt), 32'd3);
    check_eq("flush_beat_cnt",  32'(beat_cnt),  32'd5);
    reset_pulse();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    check_eq("sat_three", 32'(s_beat_cnt), 32'd3);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
    check_eq("sat_hold",  32'(s_beat_cnt), 32'd3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
`else
    check_eq("beat_cnt_tied",  32'(beat_cnt),  32'd0);
    check_eq("stall_cnt_tied", 32'(stall_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
